dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data RAM between the processor core and a host/debug port (program loader, memory inspector). It sits between the core's load/store path and the data RAM instance, and returns a stall to the core whenever the core's access is not granted. Arbitration uses core-priority with a host starvation limit and an optional host lock for multi-beat transfers. Read data is returned with the RAM's fixed one-cycle latency.

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core and a host/debug port: core priority,
// host starvation limit, host lock with a bounded burst; zero-cycle issue, one-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, CORE_OWN, HOST_OWN, HOST_LOCKED} state_t;

  state_t                state, state_nxt;
  logic [SW-1:0]         starve_cnt, starve_nxt;
  logic [LW-1:0]         lock_cnt, lock_nxt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] core_rdata_q, host_rdata_q;

  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (state == HOST_LOCKED && host_req && lock_cnt < LOCK_TOP)
      host_gnt = 1'b1;
    else if (state == HOST_LOCKED && lock_cnt == LOCK_TOP && core_req)
      core_gnt = 1'b1;
    else if (host_req && starve_cnt == STARVE_TOP)
      host_gnt = 1'b1;
    else if (core_req)
      core_gnt = 1'b1;
    else if (host_req)
      host_gnt = 1'b1;
  end

  // Only a locked host grant carries lock_cnt forward; every other outcome clears it.
  always_comb begin
    state_nxt  = IDLE;
    lock_nxt   = '0;
    starve_nxt = '0;
    if (host_gnt && host_lock) begin
      state_nxt = HOST_LOCKED;
      lock_nxt  = (lock_cnt == LOCK_TOP) ? lock_cnt : lock_cnt + 1'b1;
    end else if (host_gnt) begin
      state_nxt = HOST_OWN;
    end else if (core_gnt) begin
      state_nxt = CORE_OWN;
    end
    if (host_req && !host_gnt)
      starve_nxt = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + 1'b1;
  end

  assign core_stall = core_req & ~core_gnt;
  assign ram_addr   = core_gnt ? core_addr : (host_gnt ? host_addr : last_addr);
  assign ram_wdata  = host_gnt ? host_wdata : core_wdata;
  assign ram_we     = (core_gnt & core_we) | (host_gnt & host_we);

  // RAM data arrives in the rvalid cycle, so it is forwarded then and held afterwards.
  assign core_rdata = core_rvalid ? ram_rdata : core_rdata_q;
  assign host_rdata = host_rvalid ? ram_rdata : host_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      lock_cnt     <= '0;
      last_addr    <= '0;
      core_rvalid  <= 1'b0;
      host_rvalid  <= 1'b0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      lock_cnt    <= lock_nxt;
      core_rvalid <= core_gnt & ~core_we;
      host_rvalid <= host_gnt & ~host_we;
      if (core_gnt || host_gnt)
        last_addr <= ram_addr;
      if (core_rvalid)
        core_rdata_q <= ram_rdata;
      if (host_rvalid)
        host_rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: synchronous RAM model plus a rule-level reference model of grants,
// counters and read return, compared every cycle.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int LM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    logic [AW-1:0] a8;
    a8 = AW'(a);
    return {24'hC0FFEE, a8};
  endfunction

  // Bench RAM: reloads its known pattern while rst is high, otherwise one-cycle read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  bit            m_locked, m_pend_c, m_pend_h;
  int            m_lock_cnt, m_starve;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_pend_data, m_crdata, m_hrdata;
  logic [DW-1:0] gm [256];
  bit            e_cgnt = 1'b0, e_hgnt = 1'b0;
  logic [109:0]  obs, expv;
  int            n_vec = 0, n_bad = 0;

  task automatic apply(input bit r, input bit cr, input bit cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cwd, input bit hr, input bit hwe,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hwd, input bit hl);
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, owd, ecr, ehr;
    bit ewe;
    @(negedge clk);
    rst = r; core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd; host_lock = hl;
    e_cgnt = 1'b0;
    e_hgnt = 1'b0;
    if (m_locked && hr && m_lock_cnt < LM)       e_hgnt = 1'b1;
    else if (m_locked && m_lock_cnt == LM && cr) e_cgnt = 1'b1;
    else if (hr && m_starve == SL)               e_hgnt = 1'b1;
    else if (cr)                                 e_cgnt = 1'b1;
    else if (hr)                                 e_hgnt = 1'b1;
    ea  = e_cgnt ? ca : (e_hgnt ? ha : m_last_addr);
    ewe = (e_cgnt && cwe) || (e_hgnt && hwe);
    ewd = '0;
    if (ewe) ewd = e_cgnt ? cwd : hwd;
    ecr = m_pend_c ? m_pend_data : m_crdata;
    ehr = m_pend_h ? m_pend_data : m_hrdata;
    expv = {e_cgnt, e_hgnt, cr && !e_cgnt, ewe, ea, ewd, m_pend_c, m_pend_h, ecr, ehr};
    #1;
    owd = ram_we ? ram_wdata : '0;
    obs = {core_gnt, host_gnt, core_stall, ram_we, ram_addr, owd, core_rvalid, host_rvalid,
           core_rdata, host_rdata};
  endtask

  task automatic idle(input bit r);
    apply(r, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  task automatic tick();
    bit gc, gh;
    gc = e_cgnt;
    gh = e_hgnt;
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_lock_cnt = 0; m_starve = 0; m_last_addr = '0;
      m_pend_c = 0; m_pend_h = 0; m_crdata = '0; m_hrdata = '0; m_pend_data = '0;
      for (int i = 0; i < 256; i++) gm[i] = init_word(i);
    end else begin
      if (m_pend_c) m_crdata = m_pend_data;
      if (m_pend_h) m_hrdata = m_pend_data;
      m_pend_c = gc && !core_we;
      m_pend_h = gh && !host_we;
      if (gc) begin
        m_pend_data = gm[core_addr]; m_last_addr = core_addr;
        if (core_we) gm[core_addr] = core_wdata;
      end
      if (gh) begin
        m_pend_data = gm[host_addr]; m_last_addr = host_addr;
        if (host_we) gm[host_addr] = host_wdata;
      end
      m_starve = (host_req && !gh) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
      if (gh && host_lock) begin
        m_locked = 1; m_lock_cnt = (m_lock_cnt + 1 > LM) ? LM : m_lock_cnt + 1;
      end else begin
        m_locked = 0; m_lock_cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    apply(1, 1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0);
    n_vec++;
    if (obs !== expv) begin n_bad++; $display("FAIL reset_vec: dut=%h model=%h", obs, expv); end
    n_vec++;
    if ({core_rvalid, host_rvalid, core_rdata, host_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rv=%b%b crd=%h hrd=%h want all 0", core_rvalid, host_rvalid, core_rdata, host_rdata);
    end
    tick();
    apply(0, 1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0);
    n_vec++;
    if (obs !== expv) begin n_bad++; $display("FAIL reset_release_vec: dut=%h model=%h", obs, expv); end
    n_vec++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0 || core_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt c/h=%b/%b rv=%b%b want 1/0 00", core_gnt, host_gnt, core_rvalid, host_rvalid);
    end
    tick();
    idle(0);
    n_vec++;
    if (obs !== expv) begin n_bad++; $display("FAIL reset_first_read: dut=%h model=%h", obs, expv); end
    tick();
  endtask

  task automatic test_core_only();
    apply(0, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 0);
    n_vec++;
    if (obs !== expv || ram_we !== 1'b1) begin n_bad++; $display("FAIL core_write: dut=%h model=%h", obs, expv); end
    tick();
    apply(0, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    n_vec++;
    if (obs !== expv || core_gnt !== 1'b1) begin n_bad++; $display("FAIL core_read: dut=%h model=%h", obs, expv); end
    tick();
    idle(0);
    n_vec++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF || host_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL core_readback: rv=%b rdata=%h hrv=%b want 1 deadbeef 0", core_rvalid, core_rdata, host_rvalid);
    end
    tick();
    idle(0);
    n_vec++;
    if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL core_rdata_hold: rv=%b rdata=%h want 0 deadbeef", core_rvalid, core_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit want;
    idle(0);
    tick();
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 0, AW'($urandom_range(0, 255)), 32'h0, 1, 0, AW'($urandom_range(0, 255)), 32'h0, 0);
      want = (i % 5 == 4);
      n_vec++;
      if (obs !== expv) begin n_bad++; $display("FAIL starve_vec cyc%0d: dut=%h model=%h", i, obs, expv); end
      n_vec++;
      if (host_gnt !== want || core_stall !== want || core_gnt !== !want) begin
        n_bad++;
        $display("FAIL starve_pattern cyc%0d: hgnt=%b stall=%b cgnt=%b want hgnt=%b", i, host_gnt, core_stall, core_gnt, want);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    int hcnt, run, max_run;
    logic [AW-1:0] prev_ha;
    hcnt = 0; run = 0; max_run = 0; prev_ha = '0;
    idle(0);
    tick();
    for (int i = 0; i < 26; i++) begin
      apply(0, 1, 0, AW'($urandom_range(0, 127)), 32'h0, 1, 0, AW'(8'h80 + hcnt), 32'h0, 1);
      n_vec++;
      if (obs !== expv) begin n_bad++; $display("FAIL lock_vec cyc%0d: dut=%h model=%h", i, obs, expv); end
      if (host_rvalid === 1'b1) begin
        n_vec++;
        if (host_rdata !== init_word(prev_ha)) begin
          n_bad++;
          $display("FAIL lock_rdata cyc%0d: rdata=%h want %h", i, host_rdata, init_word(prev_ha));
        end
      end
      if (host_gnt === 1'b1) begin
        run++; prev_ha = host_addr; hcnt++;
      end else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
      tick();
    end
    if (run > max_run) max_run = run;
    n_vec++;
    if (max_run != LM) begin n_bad++; $display("FAIL lock_burst_len: got %0d want %0d", max_run, LM); end
  endtask

  task automatic test_lock_drop();
    idle(0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 8'h00, 32'h0, 1, 0, AW'(8'h90 + i), 32'h0, 1);
      n_vec++;
      if (obs !== expv || host_gnt !== 1'b1) begin n_bad++; $display("FAIL lock_drop_grant%0d: dut=%h model=%h", i, obs, expv); end
      tick();
    end
    idle(0);
    n_vec++;
    if (obs !== expv) begin n_bad++; $display("FAIL lock_drop_idle: dut=%h model=%h", obs, expv); end
    tick();
    apply(0, 1, 0, 8'h05, 32'h0, 1, 0, 8'h95, 32'h0, 1);
    n_vec++;
    if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_drop_core: cgnt=%b hgnt=%b want 1 0", core_gnt, host_gnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    idle(0);
    tick();
    apply(1, 0, 0, 8'h00, 32'h0, 1, 0, 8'h33, 32'h0, 0);
    n_vec++;
    if (host_gnt !== 1'b1 || obs !== expv) begin n_bad++; $display("FAIL rst_mid_grant: dut=%h model=%h", obs, expv); end
    tick();
    idle(0);
    n_vec++;
    if (host_rvalid !== 1'b0 || core_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_rvalid: hrv=%b crv=%b want 0 0", host_rvalid, core_rvalid);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 9) < 4);
      n_vec++;
      if (obs !== expv) begin n_bad++; $display("FAIL random_vec cyc%0d: dut=%h model=%h", i, obs, expv); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    tick();
    test_reset();
    test_core_only();
    test_starvation();
    test_lock();
    test_lock_drop();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
